// File: rtl/mouse_event_pkg.sv
// Shared types for the mouse event queue: event kinds, button ids, payloads.
package mouse_event_pkg;

    localparam int unsigned MOUSE_WIDTH  = 10;
    localparam int unsigned MOUSE_HEIGHT = 10;

    // Bits needed to hold a bin index for the larger of the two axes.
    function automatic int unsigned calc_ub(input int unsigned w, input int unsigned h);
        int unsigned m;
        m = (w > h) ? w : h;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    localparam int unsigned UB = calc_ub(MOUSE_WIDTH, MOUSE_HEIGHT);

    typedef enum logic [1:0] {
        EVT_MOVE    = 2'd0,
        EVT_PRESS   = 2'd1,
        EVT_RELEASE = 2'd2
    } evt_type_t;

    localparam logic [1:0] BTN_LEFT   = 2'd0;
    localparam logic [1:0] BTN_RIGHT  = 2'd1;
    localparam logic [1:0] BTN_MIDDLE = 2'd2;

    // One queued event.
    typedef struct packed {
        evt_type_t       etype;
        logic [1:0]      btn;
        logic [UB-1:0]   x;
        logic [UB-1:0]   y;
    } mouse_evt_t;

    // Snapshot of the mouse controller outputs.
    typedef struct packed {
        logic            left;
        logic            right;
        logic            middle;
        logic [UB-1:0]   x;
        logic [UB-1:0]   y;
    } mouse_state_t;

endpackage

// File: rtl/event_fifo.sv
// Generic synchronous show-ahead FIFO with flush.
module event_fifo #(
    parameter  int unsigned DEPTH = 8,
    parameter  int unsigned DW    = 8,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CNTW  = AW + 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clear,
    input  logic            push,
    input  logic [DW-1:0]   push_data,
    input  logic            pop,
    output logic [DW-1:0]   head,
    output logic            valid,
    output logic            full,
    output logic [CNTW-1:0] count
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign valid   = (count != '0);
    assign full    = (count == CNTW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && valid;
    assign head    = valid ? mem[rd_ptr] : '0;

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CNTW'(do_push) - CNTW'(do_pop);
        end
    end

    // Storage; contents are only observable through valid entries.
    always_ff @(posedge clk) begin
        if (reset_n && !clear && do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mouse_event_queue.sv
// Filters mouse controller outputs and queues MOVE/PRESS/RELEASE events.
module mouse_event_queue
    import mouse_event_pkg::*;
#(
    parameter  int unsigned WIDTH  = MOUSE_WIDTH,
    parameter  int unsigned HEIGHT = MOUSE_HEIGHT,
    parameter  int unsigned DEPTH  = 8,
    parameter  int unsigned STABLE = 4,
    localparam int unsigned XY_W   = calc_ub(WIDTH, HEIGHT),
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic             CLOCK_50,
    input  logic             reset_n,
    input  logic             button_left,
    input  logic             button_right,
    input  logic             button_middle,
    input  logic [XY_W-1:0]  bin_x,
    input  logic [XY_W-1:0]  bin_y,
    input  logic             clear,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [1:0]       evt_type,
    output logic [1:0]       evt_btn,
    output logic [XY_W-1:0]  evt_x,
    output logic [XY_W-1:0]  evt_y,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned CW = $clog2(STABLE + 1);

    typedef enum logic [2:0] {
        SEL_NONE, SEL_LEFT, SEL_RIGHT, SEL_MIDDLE, SEL_MOVE
    } evt_sel_t;

    mouse_state_t sample_c;
    mouse_state_t raw_q;
    mouse_state_t cand_q;
    mouse_state_t cand_d;
    mouse_state_t filt_q;
    mouse_state_t last_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    mouse_evt_t   evt_c;
    mouse_evt_t   head;
    evt_sel_t     sel_c;
    logic         push_c;

    assign sample_c = {button_left, button_right, button_middle, UB'(bin_x), UB'(bin_y)};

    // Next candidate and stability count from the registered sample.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (raw_q != cand_q) begin
            cand_d = raw_q;
            cnt_d  = CW'(1);
        end else if (cnt_q < CW'(STABLE)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Input register, candidate tracking and filtered state update.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            raw_q  <= '0;
            cand_q <= '0;
            cnt_q  <= '0;
            filt_q <= '0;
        end else begin
            raw_q  <= sample_c;
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            if (cnt_d == CW'(STABLE)) filt_q <= cand_d;
        end
    end

    // Priority encoder: first differing field between filtered and last-reported.
    always_comb begin
        evt_c   = '0;
        sel_c   = SEL_NONE;
        evt_c.x = filt_q.x;
        evt_c.y = filt_q.y;
        if (filt_q.left != last_q.left) begin
            sel_c       = SEL_LEFT;
            evt_c.etype = filt_q.left ? EVT_PRESS : EVT_RELEASE;
            evt_c.btn   = BTN_LEFT;
        end else if (filt_q.right != last_q.right) begin
            sel_c       = SEL_RIGHT;
            evt_c.etype = filt_q.right ? EVT_PRESS : EVT_RELEASE;
            evt_c.btn   = BTN_RIGHT;
        end else if (filt_q.middle != last_q.middle) begin
            sel_c       = SEL_MIDDLE;
            evt_c.etype = filt_q.middle ? EVT_PRESS : EVT_RELEASE;
            evt_c.btn   = BTN_MIDDLE;
        end else if ((filt_q.x != last_q.x) || (filt_q.y != last_q.y)) begin
            sel_c       = SEL_MOVE;
            evt_c.etype = EVT_MOVE;
            evt_c.btn   = BTN_LEFT;
        end
    end

    assign push_c = (sel_c != SEL_NONE) && !full && !clear;

    // Last-reported state: only the field behind an enqueued event advances.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            last_q <= '0;
        end else if (clear) begin
            last_q <= filt_q;
        end else if (push_c) begin
            case (sel_c)
                SEL_LEFT:   last_q.left   <= filt_q.left;
                SEL_RIGHT:  last_q.right  <= filt_q.right;
                SEL_MIDDLE: last_q.middle <= filt_q.middle;
                SEL_MOVE: begin
                    last_q.x <= filt_q.x;
                    last_q.y <= filt_q.y;
                end
                default: ;
            endcase
        end
    end

    event_fifo #(
        .DEPTH (DEPTH),
        .DW    ($bits(mouse_evt_t))
    ) u_fifo (
        .clk       (CLOCK_50),
        .reset_n   (reset_n),
        .clear     (clear),
        .push      (push_c),
        .push_data (evt_c),
        .pop       (evt_valid && evt_ready),
        .head      (head),
        .valid     (evt_valid),
        .full      (full),
        .count     (count)
    );

    assign evt_type = 2'(head.etype);
    assign evt_btn  = head.btn;
    assign evt_x    = XY_W'(head.x);
    assign evt_y    = XY_W'(head.y);

endmodule

// File: tb/tb_mouse_event_queue.sv
// Scoreboard bench for mouse_event_queue (STABLE=4, DEPTH=8, 10x10 bins).
module tb_mouse_event_queue;
    import mouse_event_pkg::*;

    localparam int unsigned XW     = calc_ub(10, 10);
    localparam int unsigned STB    = 4;
    localparam int unsigned DEP    = 8;
    localparam int unsigned CNT_W  = $clog2(DEP) + 1;

    typedef struct {
        logic [1:0]    t;
        logic [1:0]    b;
        logic [XW-1:0] x;
        logic [XW-1:0] y;
    } exp_t;

    logic             CLOCK_50 = 1'b0;
    logic             reset_n;
    logic             button_left, button_right, button_middle;
    logic [XW-1:0]    bin_x, bin_y;
    logic             clear;
    logic             evt_valid;
    logic             evt_ready;
    logic [1:0]       evt_type, evt_btn;
    logic [XW-1:0]    evt_x, evt_y;
    logic             full;
    logic [CNT_W-1:0] count;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    mouse_event_queue #(
        .WIDTH (10), .HEIGHT (10), .DEPTH (DEP), .STABLE (STB)
    ) dut (
        .CLOCK_50      (CLOCK_50),
        .reset_n       (reset_n),
        .button_left   (button_left),
        .button_right  (button_right),
        .button_middle (button_middle),
        .bin_x         (bin_x),
        .bin_y         (bin_y),
        .clear         (clear),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_type      (evt_type),
        .evt_btn       (evt_btn),
        .evt_x         (evt_x),
        .evt_y         (evt_y),
        .full          (full),
        .count         (count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic expect_evt(input logic [1:0] t, input logic [1:0] b,
                              input logic [XW-1:0] x, input logic [XW-1:0] y);
        exp_t e;
        e.t = t; e.b = b; e.x = x; e.y = y;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_q.size() == 0 && !evt_valid) break;
            tick(1);
        end
        check("drain_remaining", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every accepted head entry is compared against the scoreboard.
    always @(negedge CLOCK_50) begin
        exp_t e;
        if (reset_n === 1'b1 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_event: got type=%0d btn=%0d x=%0d y=%0d, expected none (t=%0t)",
                         evt_type, evt_btn, evt_x, evt_y, $time);
            end else begin
                e = exp_q.pop_front();
                check("evt_type", 32'(evt_type), 32'(e.t));
                check("evt_btn",  32'(evt_btn),  32'(e.b));
                check("evt_x",    32'(evt_x),    32'(e.x));
                check("evt_y",    32'(evt_y),    32'(e.y));
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL timeout: simulation did not finish, expected finish before 200us");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; clear = 1'b0; evt_ready = 1'b1;
        button_left = 1'b0; button_right = 1'b0; button_middle = 1'b0;
        bin_x = '0; bin_y = '0;
        tick(3);

        // Reset state
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_full",  32'(full),      32'd0);
        check("rst_count", 32'(count),     32'd0);
        check("rst_type",  32'(evt_type),  32'd0);
        check("rst_btn",   32'(evt_btn),   32'd0);
        check("rst_x",     32'(evt_x),     32'd0);
        check("rst_y",     32'(evt_y),     32'd0);
        reset_n = 1'b1;

        // Idle inputs produce nothing
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("idle_valid", 32'(evt_valid), 32'd0);
        end
        check("idle_count", 32'(count), 32'd0);

        // Single move; valid first rises after edge STABLE+2
        expect_evt(EVT_MOVE, BTN_LEFT, XW'(3), XW'(0));
        bin_x = XW'(3);
        for (int k = 1; k <= STB + 2; k++) begin
            tick(1);
            check("latency_valid", 32'(evt_valid), (k == STB + 2) ? 32'd1 : 32'd0);
        end
        wait_drain(30);

        // Simultaneous left/right press plus y move: priority order
        expect_evt(EVT_PRESS, BTN_LEFT,  XW'(3), XW'(2));
        expect_evt(EVT_PRESS, BTN_RIGHT, XW'(3), XW'(2));
        expect_evt(EVT_MOVE,  BTN_LEFT,  XW'(3), XW'(2));
        button_left = 1'b1; button_right = 1'b1; bin_y = XW'(2);
        wait_drain(40);

        // Glitch shorter than STABLE is filtered out
        button_middle = 1'b1;
        tick(STB - 1);
        button_middle = 1'b0;
        tick(20);
        check("glitch_count", 32'(count), 32'd0);

        // Fill the FIFO with 9 toggles, then coalesce moves while full
        evt_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            button_left = ~button_left;
            if (i <= int'(DEP))
                expect_evt(button_left ? EVT_PRESS : EVT_RELEASE, BTN_LEFT, XW'(3), XW'(2));
            tick(STB + 4);
        end
        check("fill_full",  32'(full),  32'd1);
        check("fill_count", 32'(count), 32'(DEP));
        // Pending left release and coalesced move carry the latest position
        expect_evt(EVT_RELEASE, BTN_LEFT, XW'(5), XW'(2));
        expect_evt(EVT_MOVE,    BTN_LEFT, XW'(5), XW'(2));
        for (int v = 1; v <= 5; v++) begin
            bin_x = XW'(v);
            tick(STB + 2);
        end
        tick(STB + 2);
        check("held_full",  32'(full),  32'd1);
        check("held_count", 32'(count), 32'(DEP));
        evt_ready = 1'b1;
        wait_drain(80);

        // Clear at count=5 coinciding with a push
        evt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            button_right = ~button_right;
            tick(STB + 4);
        end
        check("pre_clear_count", 32'(count), 32'd5);
        bin_y = XW'(7);
        tick(STB + 1);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("clear_count", 32'(count),     32'd0);
        check("clear_valid", 32'(evt_valid), 32'd0);
        tick(20);
        check("post_clear_count", 32'(count), 32'd0);
        evt_ready = 1'b1;
        tick(10);

        // Reset mid-transfer discards queued entries
        evt_ready = 1'b0;
        button_middle = 1'b1;
        tick(STB + 4);
        button_middle = 1'b0;
        tick(STB + 4);
        check("pre_reset_count", 32'(count), 32'd2);
        button_left = 1'b0; button_right = 1'b0; bin_x = '0; bin_y = '0;
        reset_n = 1'b0;
        tick(2);
        check("mid_rst_count", 32'(count),     32'd0);
        check("mid_rst_valid", 32'(evt_valid), 32'd0);
        check("mid_rst_full",  32'(full),      32'd0);
        reset_n = 1'b1;
        evt_ready = 1'b1;
        tick(20);
        check("post_rst_count", 32'(count), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
